// File: rtl/cmos_frame_writer.sv
// Buffers one CMOS frame of packed pixels and writes it to a frame-buffer slot in fixed-length bursts.
// Optional FRAME_WRITER_STATS_EN adds a saturating drop_cnt output for FIFO-full drops.
module cmos_frame_writer #(
  parameter int unsigned        DATA_W       = 16,
  parameter int unsigned        ADDR_W       = 24,
  parameter logic [ADDR_W-1:0]  BASE_ADDR    = '0,
  parameter logic [ADDR_W-1:0]  FRAME_STRIDE = ADDR_W'(24'h80000),
  parameter int unsigned        FRAME_WORDS  = 307200,
  parameter int unsigned        BURST_LEN    = 64,
  parameter int unsigned        FIFO_AW      = 8
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              write_req,
  input  logic [1:0]        write_addr_index,
  output logic              write_req_ack,
  input  logic              pix_de,
  input  logic [DATA_W-1:0] pix_data,
  output logic              wr_burst_req,
  output logic [9:0]        wr_burst_len,
  output logic [ADDR_W-1:0] wr_burst_addr,
  input  logic              wr_burst_data_req,
  output logic [DATA_W-1:0] wr_burst_data,
  input  logic              wr_burst_finish,
  output logic              frame_done,
`ifdef FRAME_WRITER_STATS_EN
  output logic [15:0]       drop_cnt,
`endif
  output logic              overflow
);

  localparam int unsigned      DEPTH   = 1 << FIFO_AW;
  localparam int unsigned      CNT_W   = $clog2(FRAME_WORDS + BURST_LEN + 1);
  localparam logic [CNT_W-1:0] FRAME_C = CNT_W'(FRAME_WORDS);
  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST_LEN);

  typedef enum logic [2:0] {StIdle, StAck, StFill, StReq, StDone} state_e;
  state_e state_q, state_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [FIFO_AW:0]  wr_ptr_q, rd_ptr_q, level;
  logic [CNT_W-1:0]  in_cnt_q, out_cnt_q, out_cnt_nxt, rem;
  logic [9:0]        cur_len, len_q, burst_cnt_q;
  logic [ADDR_W-1:0] base_q, addr_q;
  logic              overflow_q;
  logic              fifo_full, fifo_empty, burst_ready;
  logic              take, push, drop, grant, pop;

  always_comb begin
    level      = wr_ptr_q - rd_ptr_q;
    fifo_full  = (level == (FIFO_AW + 1)'(DEPTH));
    fifo_empty = (level == '0);
    rem        = FRAME_C - out_cnt_q;
    cur_len    = (rem > BURST_C) ? 10'(BURST_C) : 10'(rem);
    // Once the whole frame has been taken in nothing more will arrive, so a tail short
    // of words (after drops) must still be issued or the frame would never finish.
    burst_ready = (32'(level) >= 32'(cur_len)) || (in_cnt_q == FRAME_C);
    take  = ((state_q == StFill) || (state_q == StReq)) && pix_de && (in_cnt_q < FRAME_C);
    push  = take && !fifo_full;
    drop  = take && fifo_full;
    // A granted slot consumes an address even if the FIFO is empty; the pointer only
    // moves when a word is really there.
    grant = (state_q == StReq) && wr_burst_data_req && (burst_cnt_q < len_q);
    pop   = grant && !fifo_empty;
    out_cnt_nxt = out_cnt_q + CNT_W'(grant);
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (write_req) state_d = StAck;
      StAck:   state_d = StFill;
      StFill: begin
        if (write_req)        state_d = StAck;
        else if (burst_ready) state_d = StReq;
      end
      StReq: begin
        if (wr_burst_finish) begin
          if (write_req)                   state_d = StAck;
          else if (out_cnt_nxt == FRAME_C) state_d = StDone;
          else                             state_d = StFill;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    write_req_ack = (state_q == StAck);
    frame_done    = (state_q == StDone);
    wr_burst_req  = (state_q == StReq);
    wr_burst_len  = len_q;
    wr_burst_addr = addr_q;
    wr_burst_data = wr_burst_req ? mem[rd_ptr_q[FIFO_AW-1:0]] : '0;
    overflow      = overflow_q;
  end

  always_ff @(posedge pclk) begin
    if (push) mem[wr_ptr_q[FIFO_AW-1:0]] <= pix_data;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      base_q      <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      burst_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (state_q == StAck) begin
        base_q     <= BASE_ADDR + ADDR_W'(write_addr_index) * FRAME_STRIDE;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        in_cnt_q   <= '0;
        out_cnt_q  <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (take) in_cnt_q <= in_cnt_q + 1'b1;
        if (drop) overflow_q <= 1'b1;
        out_cnt_q <= out_cnt_nxt;
      end
      if ((state_q == StFill) && (state_d == StReq)) begin
        len_q       <= cur_len;
        addr_q      <= base_q + ADDR_W'(out_cnt_q);
        burst_cnt_q <= '0;
      end else if (grant) begin
        burst_cnt_q <= burst_cnt_q + 1'b1;
      end
    end
  end

`ifdef FRAME_WRITER_STATS_EN
  logic [15:0] drop_cnt_q;
  always_ff @(posedge pclk or posedge rst) begin
    if (rst)                                drop_cnt_q <= '0;
    else if (state_q == StAck)              drop_cnt_q <= '0;
    else if (drop && (drop_cnt_q != '1))    drop_cnt_q <= drop_cnt_q + 1'b1;
  end
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_cmos_frame_writer.sv
// Directed bench for cmos_frame_writer: 200-word frames, 64-word bursts, 128-deep FIFO.
module tb_cmos_frame_writer;

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic        write_req = 1'b0;
  logic [1:0]  write_addr_index = 2'd0;
  logic        write_req_ack;
  logic        pix_de = 1'b0;
  logic [15:0] pix_data = 16'h0;
  logic        wr_burst_req;
  logic [9:0]  wr_burst_len;
  logic [23:0] wr_burst_addr;
  logic        wr_burst_data_req = 1'b0;
  logic [15:0] wr_burst_data;
  logic        wr_burst_finish = 1'b0;
  logic        frame_done;
  logic        overflow;
`ifdef FRAME_WRITER_STATS_EN
  logic [15:0] drop_cnt;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  int          done_seen = 0;
  // Pixel source: main sequence owns run/start/total/base, the generator owns sent.
  logic        pix_run = 1'b0;
  int          pix_sent = 0;
  int          pix_start = 0;
  int          pix_total = 0;
  logic [15:0] pix_base = 16'h0;

  cmos_frame_writer #(
    .DATA_W(16), .ADDR_W(24), .BASE_ADDR(24'h0), .FRAME_STRIDE(24'h80000),
    .FRAME_WORDS(200), .BURST_LEN(64), .FIFO_AW(7)
  ) dut (
    .pclk              (pclk),
    .rst               (rst),
    .write_req         (write_req),
    .write_addr_index  (write_addr_index),
    .write_req_ack     (write_req_ack),
    .pix_de            (pix_de),
    .pix_data          (pix_data),
    .wr_burst_req      (wr_burst_req),
    .wr_burst_len      (wr_burst_len),
    .wr_burst_addr     (wr_burst_addr),
    .wr_burst_data_req (wr_burst_data_req),
    .wr_burst_data     (wr_burst_data),
    .wr_burst_finish   (wr_burst_finish),
    .frame_done        (frame_done),
`ifdef FRAME_WRITER_STATS_EN
    .drop_cnt          (drop_cnt),
`endif
    .overflow          (overflow)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) begin
    #1;
    if (pix_run && (pix_sent - pix_start) < pix_total) begin
      pix_de   = 1'b1;
      pix_data = pix_base + 16'(pix_sent - pix_start);
      pix_sent = pix_sent + 1;
    end else begin
      pix_de = 1'b0;
    end
  end

  always @(negedge pclk) if (frame_done === 1'b1) done_seen = done_seen + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic request(input logic [1:0] idx);
    write_req        = 1'b1;
    write_addr_index = idx;
    tick();
    check("ack_rise", write_req_ack, 1);
    write_req = 1'b0;
    tick();
    check("ack_width", write_req_ack, 0);
  endtask

  task automatic wait_req();
    for (int c = 0; c < 2000 && wr_burst_req !== 1'b1; c++) tick();
    check("req_wait", wr_burst_req, 1);
  endtask

  task automatic wait_pixels(input int n);
    for (int c = 0; c < 2000 && (pix_sent - pix_start) < n; c++) tick();
    check("pix_sent", pix_sent - pix_start, n);
  endtask

  task automatic start_pixels(input int total);
    pix_base  = pix_base + 16'h1000;
    pix_start = pix_sent;
    pix_total = total;
    pix_run   = 1'b1;
  endtask

  task automatic pop_burst(input int len, input logic [15:0] first, input int chk_n);
    for (int i = 0; i < len; i++) begin
      if (i < chk_n) check("burst_data", wr_burst_data, 32'(first + 16'(i)));
      wr_burst_data_req = 1'b1;
      tick();
    end
    wr_burst_data_req = 1'b0;
    wr_burst_finish   = 1'b1;
    tick();
    wr_burst_finish   = 1'b0;
  endtask

  task automatic run_frame(input logic [1:0] idx, input int total);
    logic [23:0] base;
    base = 24'(idx) * 24'h80000;
    request(idx);
    start_pixels(total);
    for (int k = 0; k < 4; k++) begin
      wait_req();
      check("burst_len", wr_burst_len, (k < 3) ? 64 : 8);
      check("burst_addr", wr_burst_addr, 32'(base + 24'(64 * k)));
      pop_burst((k < 3) ? 64 : 8, pix_base + 16'(64 * k), (k < 3) ? 64 : 8);
    end
    check("frame_done", frame_done, 1);
    tick();
    check("frame_done_width", frame_done, 0);
    wait_pixels(total);
    pix_run = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    check("rst_ack", write_req_ack, 0);
    check("rst_req", wr_burst_req, 0);
    check("rst_len", wr_burst_len, 0);
    check("rst_addr", wr_burst_addr, 0);
    check("rst_done", frame_done, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    tick();

    // Normal frames: slot 2 first, then the remaining slots for distinct bases.
    run_frame(2'd2, 200);
    run_frame(2'd0, 200);
    run_frame(2'd1, 200);
    run_frame(2'd3, 200);

    // Surplus pixels past the frame are ignored without flagging overflow.
    run_frame(2'd0, 210);
    check("surplus_ovf", overflow, 0);

    // Stall the first burst until the FIFO is full, then push 5 more pixels.
    request(2'd0);
    start_pixels(133);
    wait_req();
    check("ovf_len0", wr_burst_len, 64);
    wait_pixels(133);
    repeat (2) tick();
    check("ovf_set", overflow, 1);
`ifdef FRAME_WRITER_STATS_EN
    check("drop_cnt", drop_cnt, 5);
`endif
    pop_burst(64, pix_base, 64);
    pix_total = 200;
    wait_req();
    check("ovf_addr1", wr_burst_addr, 64);
    pop_burst(64, pix_base + 16'd64, 64);
    wait_req();
    check("ovf_addr2", wr_burst_addr, 128);
    pop_burst(64, pix_base + 16'd133, 64);
    wait_req();
    check("ovf_len3", wr_burst_len, 8);
    check("ovf_addr3", wr_burst_addr, 192);
    pop_burst(8, pix_base + 16'd197, 3);
    check("ovf_frame_done", frame_done, 1);
    check("ovf_sticky", overflow, 1);
    wait_pixels(200);
    pix_run = 1'b0;
    tick();

    // Restart while filling: abandoned frame, overflow cleared on ack.
    request(2'd1);
    check("ovf_cleared", overflow, 0);
    start_pixels(30);
    wait_pixels(30);
    repeat (2) tick();
    check("fill_no_req", wr_burst_req, 0);
    pix_run = 1'b0;
    run_frame(2'd2, 200);

    // Restart request during a burst is held off until finish.
    request(2'd3);
    start_pixels(200);
    wait_req();
    check("midreq_addr", wr_burst_addr, 24'h180000);
    write_req        = 1'b1;
    write_addr_index = 2'd1;
    repeat (3) tick();
    check("midreq_no_ack", write_req_ack, 0);
    check("midreq_held", wr_burst_req, 1);
    pop_burst(64, pix_base, 64);
    check("midreq_ack", write_req_ack, 1);
    write_req = 1'b0;
    pix_run   = 1'b0;
    tick();
    start_pixels(200);
    wait_req();
    check("restart_addr", wr_burst_addr, 24'h080000);

    // Asynchronous reset in the middle of a burst.
    pix_run = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_req", wr_burst_req, 0);
    check("arst_len", wr_burst_len, 0);
    check("arst_addr", wr_burst_addr, 0);
    check("arst_data", wr_burst_data, 0);
    check("arst_ack", write_req_ack, 0);
    check("arst_ovf", overflow, 0);
    tick();
    rst = 1'b0;
    tick();
    run_frame(2'd1, 200);

    check("frames_done", done_seen, 8);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
